// File: rtl/secp256k1_pkg.sv
// Shared secp256k1 field constants, the arbiter state encoding and the default
// abort limit for the modular-reduction arbiter.
package secp256k1_pkg;

  // p = 2^256 - 2^32 - 977
  localparam logic [255:0] P = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
  localparam int unsigned  TimeoutDefault = 63;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StBusy,
    StResp
  } state_e;

endpackage

// File: rtl/ff_reduce_secp256k1.sv
// Iterative reduction of a 512-bit value mod p: fold the high half using
// 2^256 == 2^32 + 977 (mod p) until it is zero, then subtract p while needed.
module ff_reduce_secp256k1
  import secp256k1_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [511:0] a_i,
  output logic         done_o,
  output logic [255:0] r_o
);

  logic [511:0] acc_q, acc_d;
  logic         done_q, done_d;
  logic [511:0] hi_ext;
  logic [511:0] fold;

  always_comb begin
    hi_ext = {256'b0, acc_q[511:256]};
    fold   = (hi_ext << 32) + (hi_ext * 512'd977) + {256'b0, acc_q[255:0]};
    acc_d  = acc_q;
    done_d = done_q;
    if (rst_i) begin
      acc_d  = a_i;
      done_d = 1'b0;
    end else if (!done_q) begin
      if (acc_q[511:256] != 256'b0) begin
        acc_d = fold;
      end else if (acc_q[255:0] >= P) begin
        acc_d = acc_q - {256'b0, P};
      end else begin
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    acc_q  <= acc_d;
    done_q <= done_d;
  end

  assign done_o = done_q;
  assign r_o    = acc_q[255:0];

endmodule

// File: rtl/ff_reduce_arbiter.sv
// Two-requester round-robin front end for a single mod-p reducer, with a BUSY
// timeout that returns an error result instead of hanging.
module ff_reduce_arbiter
  import secp256k1_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = TimeoutDefault
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   in_valid,
  output logic [1:0]   in_ready,
  input  logic [511:0] in_a0,
  input  logic [511:0] in_a1,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         out_id,
  output logic [255:0] out_a,
  output logic         out_err,
  output logic         busy
);

  localparam logic [7:0] ToLast = 8'(TIMEOUT_CYCLES - 1);

  state_e       state_q, state_d;
  logic [511:0] opnd_q, opnd_d;
  logic         id_q, id_d;
  logic         prio_q, prio_d;  // requester that wins when both are valid
  logic [7:0]   cnt_q, cnt_d;
  logic [255:0] out_a_q, out_a_d;
  logic         err_q, err_d;
  logic         grant;
  logic         red_rst;
  logic         red_done;
  logic [255:0] red_r;

  assign red_rst = !reset_n || (state_q == StLoad);

  ff_reduce_secp256k1 u_reduce (
    .clk_i  (clk),
    .rst_i  (red_rst),
    .a_i    (opnd_q),
    .done_o (red_done),
    .r_o    (red_r)
  );

  always_comb begin
    state_d  = state_q;
    opnd_d   = opnd_q;
    id_d     = id_q;
    prio_d   = prio_q;
    cnt_d    = cnt_q;
    out_a_d  = out_a_q;
    err_d    = err_q;
    in_ready = 2'b00;
    grant    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid != 2'b00) begin
          grant    = (in_valid == 2'b11) ? prio_q : in_valid[1];
          in_ready = grant ? 2'b10 : 2'b01;
          opnd_d   = grant ? in_a1 : in_a0;
          id_d     = grant;
          prio_d   = ~grant;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        cnt_d   = 8'd0;
        state_d = StBusy;
      end
      StBusy: begin
        // done takes priority over a coincident timeout
        if (red_done) begin
          out_a_d = red_r;
          err_d   = 1'b0;
          state_d = StResp;
        end else if (cnt_q == ToLast) begin
          out_a_d = 256'b0;
          err_d   = 1'b1;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (!reset_n) begin
      in_ready = 2'b00;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= StIdle;
      opnd_q  <= 512'b0;
      id_q    <= 1'b0;
      prio_q  <= 1'b0;
      cnt_q   <= 8'd0;
      out_a_q <= 256'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      opnd_q  <= opnd_d;
      id_q    <= id_d;
      prio_q  <= prio_d;
      cnt_q   <= cnt_d;
      out_a_q <= out_a_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = reset_n && (state_q == StResp);
  assign busy      = reset_n && (state_q != StIdle);
  assign out_id    = id_q;
  assign out_a     = out_a_q;
  assign out_err   = err_q;

endmodule
